nibble_adder_seq: RTL

NIBBLE_ADDER_SEQ -- requirements
Module: nibble_adder_seq

---
 rtl/nibble_adder_seq_pkg.sv | 14 +
 rtl/nibble_adder_seq_fulladder4.sv | 23 ++
 rtl/nibble_adder_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/nibble_adder_seq_pkg.sv
// Shared definitions for nibble_adder_seq.
//   NIBBLE_W : width of the single nibble adder slice
//   state_t  : control FSM states (IDLE, RUN, DONE)
package nibble_adder_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_adder_seq_fulladder4.sv
// fulladder4: 4-bit ripple adder slice, the only arithmetic resource of
// nibble_adder_seq.
//   a_i, b_i : nibble operands
//   carry_i  : carry in
//   sum_o    : nibble sum
//   carry_o  : carry out of the nibble
module fulladder4
  import nibble_adder_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                carry_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                carry_o
);

  logic [NIBBLE_W:0] w_sum;

  assign w_sum   = {1'b0, a_i} + {1'b0, b_i} + {{NIBBLE_W{1'b0}}, carry_i};
  assign sum_o   = w_sum[NIBBLE_W-1:0];
  assign carry_o = w_sum[NIBBLE_W];

endmodule

// File: rtl/nibble_adder_seq.sv
// nibble_adder_seq: WIDTH-bit add/subtract computed one nibble per cycle
// through a single fulladder4 slice.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Requests are taken only in IDLE (req_ready_o). A response is
// offered in DONE (rsp_valid_o) and held stable until rsp_ready_i is seen.
//
// Ports
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o: request handshake
//   a_i, b_i, sub_i,carry_i: operands, 1=subtract (a-b), add carry-in
//   rsp_valid_o/rsp_ready_i: response handshake
//   sum_o, carry_o         : result and final carry (1 = no borrow on sub)
//   busy_o                 : operation in progress (RUN or DONE)
//   dbg_state_o            : current FSM state, for observation only
module nibble_adder_seq
  import nibble_adder_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  input  logic             carry_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             busy_o,
  output logic [1:0]       dbg_state_o
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  // Counter also holds NIB: the cycle after the last nibble, which makes the
  // response appear NIB+1 cycles after acceptance.
  localparam int CNT_W = $clog2(NIB + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_sub;
  logic               r_carry;
  logic [WIDTH-1:0]   r_result;
  logic [CNT_W-1:0]   r_cnt;

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_b_eff;
  logic [NIBBLE_W-1:0] w_fa_sum;
  logic                w_fa_carry;
  logic                w_accept;
  logic                w_last;
  logic                w_step;

  assign w_accept = (r_state == IDLE) && req_valid_i;
  assign w_last   = (r_cnt == CNT_W'(NIB));
  assign w_step   = (r_state == RUN) && !w_last;

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid_i) w_state_nxt = RUN;
      RUN:     if (w_last)      w_state_nxt = DONE;
      DONE:    if (rsp_ready_i) w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  // Select the current nibble; out-of-range counter values yield zero.
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_a_nib = r_a[i*NIBBLE_W +: NIBBLE_W];
        w_b_nib = r_b[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  // Subtract as a + ~b + 1; the +1 comes from the carry register preload.
  assign w_b_eff = r_sub ? ~w_b_nib : w_b_nib;

  fulladder4 u_fa (
    .a_i     (w_a_nib),
    .b_i     (w_b_eff),
    .carry_i (r_carry),
    .sum_o   (w_fa_sum),
    .carry_o (w_fa_carry)
  );

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a     <= a_i;
      r_b     <= b_i;
      r_sub   <= sub_i;
      r_carry <= sub_i ? 1'b1 : carry_i;
      r_cnt   <= '0;
    end else if (w_step) begin
      for (int i = 0; i < NIB; i++) begin
        if (r_cnt == CNT_W'(i)) begin
          r_result[i*NIBBLE_W +: NIBBLE_W] <= w_fa_sum;
        end
      end
      r_carry <= w_fa_carry;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign req_ready_o = (r_state == IDLE);
  assign rsp_valid_o = (r_state == DONE);
  assign busy_o      = (r_state != IDLE);
  assign sum_o       = r_result;
  assign carry_o     = r_carry;
  assign dbg_state_o = r_state;

endmodule
